mpy_sequencer: RTL

- Operand issue/capture stage wrapped around the fixed-latency signed Booth multiplier `MPY(clk, a, b, product)`.
- Accepts operand pairs on a valid/ready input and drives them to the multiplier's a/b inputs, held stable for exactly LATENCY cycles.
- Captures the multiplier's product, then presents the result with its operands on a valid/ready output.
- Replaces the hand-timed "hold operands 8 cycles" stimulus with a reusable handshake front-end.

---
 rtl/mpy_pkg.sv | 17 +
 rtl/mpy_sequencer_if.sv | 28 ++
 rtl/mpy_wait_cnt.sv | 31 +++
 rtl/mpy_sequencer.sv | 95 +++++++++
 4 files changed

// File: rtl/mpy_pkg.sv
// Definitions shared by the multiplier sequencer: default sizes, state
// encoding and the signed operand/product types.
package mpy_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int LATENCY_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic signed [WIDTH_DEF-1:0]   operand_t;
  typedef logic signed [2*WIDTH_DEF-1:0] product_t;

endpackage

// File: rtl/mpy_sequencer_if.sv
// Operand-in / result-out handshake bundle of the multiplier sequencer.
// The slave side is the sequencer; the master side feeds operands and
// consumes results.
interface mpy_sequencer_if #(
  parameter int WIDTH = 4
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   in_a;
  logic signed [WIDTH-1:0]   in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [2*WIDTH-1:0] out_product;
  logic signed [WIDTH-1:0]   out_a;
  logic signed [WIDTH-1:0]   out_b;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, out_a, out_b
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, out_a, out_b
  );

endinterface

// File: rtl/mpy_wait_cnt.sv
// Loadable down-counter that times the multiplier latency. Loading sets
// LATENCY-1; the zero flag marks the edge on which the product is valid.
module mpy_wait_cnt #(
  parameter int LATENCY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  logic [CW-1:0] cnt;

  // Load on accept, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mpy_sequencer.sv
// Handshake front-end for a fixed-latency multiplier: captures an operand
// pair, holds it on the multiplier inputs for LATENCY cycles, samples the
// product and presents it with its operands until the consumer takes it.
module mpy_sequencer
  import mpy_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  mpy_sequencer_if.slave            bus,
  output logic signed [WIDTH-1:0]   mpy_a,
  output logic signed [WIDTH-1:0]   mpy_b,
  input  logic signed [2*WIDTH-1:0] mpy_product,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  state_t state;
  logic   accept;
  logic   cnt_zero;

  // Ready in IDLE, or in DONE when the result leaves on this same edge.
  assign bus.in_ready = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  mpy_wait_cnt #(
    .LATENCY(LATENCY)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dec  (state == ST_WAIT),
    .zero (cnt_zero)
  );

  // Sequencer FSM; every output apart from in_ready is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      mpy_a           <= '0;
      mpy_b           <= '0;
      bus.out_product <= '0;
      bus.out_a       <= '0;
      bus.out_b       <= '0;
      bus.out_valid   <= 1'b0;
      busy            <= 1'b0;
      op_count        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mpy_a     <= bus.in_a;
            mpy_b     <= bus.in_b;
            bus.out_a <= bus.in_a;
            bus.out_b <= bus.in_b;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            bus.out_product <= mpy_product;
            bus.out_valid   <= 1'b1;
            busy            <= 1'b0;
            state           <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            op_count      <= op_count + CNT_W'(1);
            bus.out_valid <= 1'b0;
            if (accept) begin
              // Next pair goes in on the same edge the result leaves.
              mpy_a     <= bus.in_a;
              mpy_b     <= bus.in_b;
              bus.out_a <= bus.in_a;
              bus.out_b <= bus.in_b;
              busy      <= 1'b1;
              state     <= ST_WAIT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
